core_ctrl: RTL

Instruction sequencer that generates the 50-bit `inst` word for `core` to run one complete output tile. It runs weight fetch into L0, weight load into the PE array, activation fetch, execute, and OFIFO drain into PMEM. It sits between the testbench/host and `core`, replacing hand-written instruction streams. A single `start` pulse runs the full tile, and `done` marks its end.

---
 rtl/core_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/core_ctrl.sv
// core_ctrl: sequences weight fetch/load, activation fetch/execute and OFIFO drain into one 50-bit inst word per cycle.
module core_ctrl #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int act_len = 36
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [10:0] w_base,
  input  logic [10:0] x_base,
  input  logic [13:0] p_base,
  input  logic        ofifo_valid,
  output logic [49:0] inst,
  output logic        busy,
  output logic        done
);
  localparam int CW = 16;
  localparam logic [CW-1:0] ROW_C = CW'(row);
  localparam logic [CW-1:0] SET_C = CW'(row + col);
  localparam logic [CW-1:0] ACT_C = CW'(act_len);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [49:0] IDLE_W = 50'h1_8001_0018_0000;
  typedef enum logic [2:0] {IDLE, W_XMEM, W_LOAD, W_SETTLE, X_XMEM, X_EXEC, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, rd_q, rd_d, wr_q, wr_d;
  logic pend_q, pend_d, mode_q, mode_d, rd;
  logic [10:0] wb_q, wb_d, xb_q, xb_d;
  logic [13:0] pb_q, pb_d;
  logic [49:0] inst_q, inst_d;
  logic busy_q, done_q;
  // inst_d describes the current state's cycle; it reaches core one edge later
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + ONE;
    rd_d = rd_q;
    wr_d = wr_q;
    pend_d = 1'b0;
    mode_d = mode_q;
    wb_d = wb_q;
    xb_d = xb_q;
    pb_d = pb_q;
    inst_d = IDLE_W;
    inst_d[2] = mode_q;
    rd = ofifo_valid && rd_q < ACT_C;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = W_XMEM;
          mode_d = mode;
          wb_d = w_base;
          xb_d = x_base;
          pb_d = p_base;
        end
      end
      W_XMEM: begin
        if (cnt_q < ROW_C) begin
          inst_d[20] = 1'b0;
          inst_d[18:8] = wb_q + cnt_q[10:0];
        end
        inst_d[3] = cnt_q != '0;
        state_d = cnt_q == ROW_C ? W_LOAD : state_q;
      end
      W_LOAD: begin
        inst_d[4] = 1'b1;
        inst_d[0] = 1'b1;
        state_d = cnt_q == ROW_C - ONE ? W_SETTLE : state_q;
      end
      W_SETTLE: state_d = cnt_q == SET_C - ONE ? X_XMEM : state_q;
      X_XMEM: begin
        if (cnt_q < ACT_C) begin
          inst_d[20] = 1'b0;
          inst_d[18:8] = xb_q + cnt_q[10:0];
        end
        inst_d[3] = cnt_q != '0;
        state_d = cnt_q == ACT_C ? X_EXEC : state_q;
      end
      X_EXEC: begin
        inst_d[4] = 1'b1;
        inst_d[1] = 1'b1;
        if (cnt_q == ACT_C - ONE) begin
          state_d = DRAIN;
          rd_d = '0;
          wr_d = '0;
        end
      end
      DRAIN: begin
        inst_d[7] = rd;
        rd_d = rd_q + CW'(rd);
        pend_d = rd;
        if (pend_q) begin
          inst_d[48] = 1'b0;
          inst_d[47] = 1'b0;
          inst_d[46:33] = pb_q + wr_q[13:0];
          wr_d = wr_q + ONE;
          state_d = wr_q == ACT_C - ONE ? DONE : state_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      pend_q <= 1'b0;
      mode_q <= 1'b0;
      wb_q <= '0;
      xb_q <= '0;
      pb_q <= '0;
      inst_q <= IDLE_W;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      pend_q <= pend_d;
      mode_q <= mode_d;
      wb_q <= wb_d;
      xb_q <= xb_d;
      pb_q <= pb_d;
      inst_q <= inst_d;
      busy_q <= state_q != IDLE;
      done_q <= state_q == DONE;
    end
  end
  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
